// File: rtl/simproc_ctrl_fsm_if.sv
// rtl/simproc_ctrl_fsm_if.sv - control/bus handshake bundle between the sequencer and the 9-bit datapath
interface simproc_ctrl_fsm_if #(
  parameter int NREG = 8
);
  logic            RUN;
  logic [8:0]      IR;
  logic            IR_LOAD;
  logic [NREG-1:0] R_OUT;
  logic            G_OUT;
  logic            DIN_OUT;
  logic [NREG-1:0] R_IN;
  logic            A_IN;
  logic            G_IN;
  logic            ADD_SUB;
  logic            DONE;
  logic            ERR;

  modport master (
    input  RUN, IR,
    output IR_LOAD, R_OUT, G_OUT, DIN_OUT, R_IN, A_IN, G_IN, ADD_SUB, DONE, ERR
  );

  modport slave (
    output RUN, IR,
    input  IR_LOAD, R_OUT, G_OUT, DIN_OUT, R_IN, A_IN, G_IN, ADD_SUB, DONE, ERR
  );
endinterface

// File: rtl/simproc_ctrl_fsm.sv
// rtl/simproc_ctrl_fsm.sv - T0..T3 sequencer for the 9-bit simple processor (mv, mvi, add, sub)
module simproc_ctrl_fsm #(
  parameter int NREG         = 8,
  parameter bit ILLEGAL_TRAP = 1'b0
) (
  input  logic                 CLK,
  input  logic                 RST,
  simproc_ctrl_fsm_if.master   bus
);

  generate
    if (NREG != 8) begin : g_nreg_check
      $error("simproc_ctrl_fsm: NREG must be 8 to match the 3-bit register fields");
    end
  endgenerate

  typedef enum logic [2:0] {
    T0   = 3'd0,
    T1   = 3'd1,
    T2   = 3'd2,
    T3   = 3'd3,
    HALT = 3'd4
  } state_t;

  state_t state_q, state_d;
  logic   err_q, err_d;

  logic [2:0]      op, rx, ry;
  logic [NREG-1:0] x_oh, y_oh;

  logic            ir_load;
  logic [NREG-1:0] r_out, r_in;
  logic            g_out, din_out, a_in, g_in, add_sub, done;

  assign op   = bus.IR[8:6];
  assign rx   = bus.IR[5:3];
  assign ry   = bus.IR[2:0];
  assign x_oh = {{(NREG-1){1'b0}}, 1'b1} << rx;
  assign y_oh = {{(NREG-1){1'b0}}, 1'b1} << ry;

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    ir_load = 1'b0;
    r_out   = '0;
    r_in    = '0;
    g_out   = 1'b0;
    din_out = 1'b0;
    a_in    = 1'b0;
    g_in    = 1'b0;
    add_sub = 1'b0;
    done    = 1'b0;
    case (state_q)
      T0: begin
        ir_load = bus.RUN;
        if (bus.RUN) state_d = T1;
      end
      T1: begin
        case (op)
          3'b000: begin
            r_out   = y_oh;
            r_in    = x_oh;
            done    = 1'b1;
            state_d = T0;
          end
          3'b001: begin
            din_out = 1'b1;
            r_in    = x_oh;
            done    = 1'b1;
            state_d = T0;
          end
          3'b010, 3'b011: begin
            r_out   = x_oh;
            a_in    = 1'b1;
            state_d = T2;
          end
          default: begin
            if (ILLEGAL_TRAP) begin
              err_d   = 1'b1;
              state_d = HALT;
            end else begin
              done    = 1'b1;
              state_d = T0;
            end
          end
        endcase
      end
      T2: begin
        // opcode LSB distinguishes sub (011) from add (010)
        r_out   = y_oh;
        g_in    = 1'b1;
        add_sub = bus.IR[6];
        state_d = T3;
      end
      T3: begin
        g_out   = 1'b1;
        r_in    = x_oh;
        done    = 1'b1;
        state_d = T0;
      end
      HALT: state_d = HALT;
      default: state_d = T0;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= T0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  // every output is forced low while reset is held, IR_LOAD included
  assign bus.IR_LOAD = ir_load & ~RST;
  assign bus.R_OUT   = r_out & {NREG{~RST}};
  assign bus.R_IN    = r_in & {NREG{~RST}};
  assign bus.G_OUT   = g_out & ~RST;
  assign bus.DIN_OUT = din_out & ~RST;
  assign bus.A_IN    = a_in & ~RST;
  assign bus.G_IN    = g_in & ~RST;
  assign bus.ADD_SUB = add_sub & ~RST;
  assign bus.DONE    = done & ~RST;
  assign bus.ERR     = ILLEGAL_TRAP ? (err_q & ~RST) : 1'b0;

endmodule
